// File: rtl/sobel_window_ctrl_if.sv
// Pixel-stream and window-tap bundle between the raster source and the Sobel kernel front-end.
interface sobel_window_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  sof_i;
  logic                  pix_valid_i;
  logic [DATA_WIDTH-1:0] pix_i;
  logic                  fsync_o;
  logic                  rsync_o;
  logic                  frame_done_o;
  logic                  frame_abort_o;
  logic [DATA_WIDTH-1:0] pData1, pData2, pData3;
  logic [DATA_WIDTH-1:0] pData4, pData5, pData6;
  logic [DATA_WIDTH-1:0] pData7, pData8, pData9;

  modport master (
    output sof_i, pix_valid_i, pix_i,
    input  fsync_o, rsync_o, frame_done_o, frame_abort_o,
    input  pData1, pData2, pData3, pData4, pData5, pData6, pData7, pData8, pData9
  );

  modport slave (
    input  sof_i, pix_valid_i, pix_i,
    output fsync_o, rsync_o, frame_done_o, frame_abort_o,
    output pData1, pData2, pData3, pData4, pData5, pData6, pData7, pData8, pData9
  );
endinterface

// File: rtl/sobel_window_ctrl.sv
// Line buffers, 3x3 window and frame sequencer feeding the Sobel kernel.
// state  | meaning
// IDLE   | waiting for an sof pixel
// FILL   | rows 0..1 arriving, no window possible yet
// ACTIVE | rows 2.. arriving, windows emitted from col 2 on
// DONE   | last pixel taken; frame_done_o asserted for one cycle
module sobel_window_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240
) (
  input  logic          pclk_i,
  input  logic          rstn_i,
  sobel_window_ctrl_if.slave bus
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_ACTIVE, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         col_q, col_d, pos_col;
  logic [RW-1:0]         row_q, row_d, pos_row;
  logic                  rsync_q, rsync_d;
  logic                  abort_q, abort_d;
  logic                  open, accept, restart, last_col, last_row;
  logic [DATA_WIDTH-1:0] win_q [9];
  logic [DATA_WIDTH-1:0] win_d [9];
  logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb2 [IMG_WIDTH];

  // An accepted sof pixel is always (0,0), whatever the counters held before.
  always_comb begin
    open     = (state_q == S_FILL) || (state_q == S_ACTIVE);
    accept   = bus.pix_valid_i && (open || bus.sof_i);
    restart  = accept && bus.sof_i;
    pos_col  = restart ? '0 : col_q;
    pos_row  = restart ? '0 : row_q;
    last_col = (pos_col == CW'(IMG_WIDTH - 1));
    last_row = (pos_row == RW'(IMG_HEIGHT - 1));
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : pos_row + 1'b1;
      end else begin
        col_d = pos_col + 1'b1;
        row_d = pos_row;
      end
    end
    rsync_d = accept && (pos_row >= RW'(2)) && (pos_col >= CW'(2));
    abort_d = restart && open;
  end

  always_comb begin
    win_d = win_q;
    if (accept) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb2[pos_col];
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb1[pos_col];
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = bus.pix_i;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (restart) state_d = S_FILL;
      S_FILL: begin
        if (restart) state_d = S_FILL;
        else if (accept && (pos_row == RW'(1)) && last_col) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (restart) state_d = S_FILL;
        else if (accept && last_row && last_col) state_d = S_DONE;
      end
      S_DONE:   state_d = restart ? S_FILL : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      rsync_q <= 1'b0;
      abort_q <= 1'b0;
      for (int k = 0; k < 9; k++) win_q[k] <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      rsync_q <= rsync_d;
      abort_q <= abort_d;
      for (int k = 0; k < 9; k++) win_q[k] <= win_d[k];
    end
  end

  // Line-buffer RAM is deliberately unreset; FILL rewrites every entry before it is read.
  always_ff @(posedge pclk_i) begin
    if (accept) begin
      lb2[pos_col] <= lb1[pos_col];
      lb1[pos_col] <= bus.pix_i;
    end
  end

  always_comb begin
    bus.fsync_o       = (state_q != S_IDLE);
    bus.frame_done_o  = (state_q == S_DONE);
    bus.rsync_o       = rsync_q;
    bus.frame_abort_o = abort_q;
    bus.pData1        = win_q[0];
    bus.pData2        = win_q[1];
    bus.pData3        = win_q[2];
    bus.pData4        = win_q[3];
    bus.pData5        = win_q[4];
    bus.pData6        = win_q[5];
    bus.pData7        = win_q[6];
    bus.pData8        = win_q[7];
    bus.pData9        = win_q[8];
  end
endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Self-checking bench: frame-position model of the window stream compared every cycle.
module tb_sobel_window_ctrl;
  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 6;

  logic pclk = 1'b0;
  logic rstn = 1'b0;
  always #5 pclk = ~pclk;

  sobel_window_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  sobel_window_ctrl #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .pclk_i (pclk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // model state: whether a frame is open, next pixel position, and the frame image so far
  bit          m_open = 1'b0;
  int          m_r = 0, m_c = 0;
  logic [7:0]  img [H][W];
  bit          e_rsync, e_fsync, e_done, e_abort, e_zero;
  logic [7:0]  e_win [9];

  int          n_rsync = 0, n_done = 0, n_abort = 0;
  bit          got_first = 1'b0;
  logic [7:0]  first_win [9];
  logic [7:0]  last_p9 = '0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge pclk) begin : model_and_compare
    bit         acc;
    logic [7:0] w [9];
    e_rsync = 1'b0;
    e_done  = 1'b0;
    e_abort = 1'b0;
    e_zero  = 1'b0;
    if (!rstn) begin
      m_open  = 1'b0;
      e_zero  = 1'b1;
      e_fsync = 1'b0;
    end else begin
      acc = bus.pix_valid_i && (bus.sof_i || m_open);
      if (acc) begin
        if (bus.sof_i) begin
          e_abort = m_open;
          m_r = 0;
          m_c = 0;
        end
        img[m_r][m_c] = bus.pix_i;
        if (m_r >= 2 && m_c >= 2) begin
          e_rsync = 1'b1;
          for (int i = 0; i < 9; i++) e_win[i] = img[m_r - 2 + i / 3][m_c - 2 + i % 3];
        end
        e_done = (m_r == H - 1) && (m_c == W - 1);
        m_open = !e_done;
        m_c++;
        if (m_c == W) begin
          m_c = 0;
          m_r++;
        end
      end
      e_fsync = m_open || e_done;
    end

    #1;
    w = '{bus.pData1, bus.pData2, bus.pData3, bus.pData4, bus.pData5,
          bus.pData6, bus.pData7, bus.pData8, bus.pData9};
    chk("rsync_o", bus.rsync_o, e_rsync);
    chk("fsync_o", bus.fsync_o, e_fsync);
    chk("frame_done_o", bus.frame_done_o, e_done);
    chk("frame_abort_o", bus.frame_abort_o, e_abort);
    if (e_rsync || e_zero)
      for (int i = 0; i < 9; i++)
        chk($sformatf("pData%0d", i + 1), w[i], e_zero ? 8'h00 : e_win[i]);
    if (bus.rsync_o === 1'b1) begin
      n_rsync++;
      if (!got_first) begin
        got_first = 1'b1;
        first_win = w;
      end
    end
    if (bus.frame_done_o === 1'b1) begin
      n_done++;
      last_p9 = w[8];
    end
    if (bus.frame_abort_o === 1'b1) n_abort++;
  end

  task automatic cyc(bit v, bit s, logic [7:0] p, bit rn = 1'b1);
    @(negedge pclk);
    bus.pix_valid_i = v;
    bus.sof_i       = s;
    bus.pix_i       = p;
    rstn            = rn;
  endtask

  task automatic idle(int n);
    repeat (n) cyc(1'b0, 1'b0, 8'h00);
  endtask

  // pat: 0 = row*16+col, 1 = random; gaps: 0 none, 1 alternate, 2 random (with stray sof)
  task automatic send_frame(int pat, int stop_idx, int gaps);
    for (int idx = 0; idx < W * H; idx++) begin
      int r, c;
      logic [7:0] p;
      if (idx == stop_idx) return;
      r = idx / W;
      c = idx % W;
      p = (pat == 0) ? 8'(r * 16 + c) : 8'($urandom);
      if (gaps == 2 && $urandom_range(0, 3) == 0)
        cyc(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
      cyc(1'b1, idx == 0, p);
      if (gaps == 1) cyc(1'b0, 1'b0, 8'($urandom));
    end
  endtask

  task automatic check_counts(string tag, int r0, int d0, int a0, int er, int ed, int ea);
    chk({tag, " windows"}, n_rsync - r0, er);
    chk({tag, " done pulses"}, n_done - d0, ed);
    chk({tag, " abort pulses"}, n_abort - a0, ea);
  endtask

  task automatic check_first(string tag);
    logic [7:0] exp_first [9];
    exp_first = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
    chk({tag, " first window seen"}, got_first, 1'b1);
    for (int i = 0; i < 9; i++)
      chk($sformatf("%s first pData%0d", tag, i + 1), first_win[i], exp_first[i]);
  endtask

  initial begin : driver
    int r0, d0, a0;
    bus.pix_valid_i = 1'b0;
    bus.sof_i       = 1'b0;
    bus.pix_i       = '0;
    repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    idle(2);

    // continuous pattern frame
    r0 = n_rsync; d0 = n_done; a0 = n_abort; got_first = 1'b0;
    send_frame(0, -1, 0);
    idle(3);
    check_counts("cont", r0, d0, a0, 24, 1, 0);
    check_first("cont");
    chk("cont last pData9", last_p9, 8'h57);

    // pix_valid toggled every cycle
    r0 = n_rsync; d0 = n_done; a0 = n_abort; got_first = 1'b0;
    send_frame(0, -1, 1);
    idle(3);
    check_counts("toggle", r0, d0, a0, 24, 1, 0);
    check_first("toggle");
    chk("toggle last pData9", last_p9, 8'h57);

    // valid pixels before any sof
    r0 = n_rsync; d0 = n_done; a0 = n_abort; got_first = 1'b0;
    repeat (5) cyc(1'b1, 1'b0, 8'($urandom));
    send_frame(0, -1, 0);
    idle(3);
    check_counts("presof", r0, d0, a0, 24, 1, 0);
    check_first("presof");

    // sof re-asserted at pixel (3,4): 6 + 2 windows from the aborted frame
    r0 = n_rsync; d0 = n_done; a0 = n_abort;
    send_frame(1, 3 * W + 4, 0);
    send_frame(1, -1, 0);
    idle(3);
    check_counts("abort", r0, d0, a0, 32, 1, 1);

    // reset at pixel (4,5): 12 + 3 windows before it
    r0 = n_rsync; d0 = n_done; a0 = n_abort;
    send_frame(1, 4 * W + 5, 0);
    cyc(1'b1, 1'b0, 8'($urandom), 1'b0);
    cyc(1'b1, 1'b0, 8'($urandom));
    send_frame(1, -1, 0);
    idle(3);
    check_counts("reset", r0, d0, a0, 39, 1, 0);

    // back-to-back frames, sof in the DONE cycle
    r0 = n_rsync; d0 = n_done; a0 = n_abort;
    repeat (3) send_frame(1, -1, 0);
    idle(3);
    check_counts("b2b", r0, d0, a0, 72, 3, 0);

    // random gaps with stray sof on idle cycles
    r0 = n_rsync; d0 = n_done; a0 = n_abort;
    repeat (2) send_frame(1, -1, 2);
    idle(3);
    check_counts("gaps", r0, d0, a0, 48, 2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sobel_window_ctrl.md
Name: sobel_window_ctrl

Overview:
- Front-end sequencer for the 3x3 Sobel edge kernel.
- Accepts a raster pixel stream and keeps two line buffers plus a 3x3 window register array.
- Drives the kernel's fsync/rsync qualifiers and the nine window taps (pData1..pData9).
- Tracks frame position with a small state machine, so the kernel only computes on complete, in-frame windows.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- IMG_WIDTH, 320, pixels per line; minimum 3.
- IMG_HEIGHT, 240, lines per frame; minimum 3.

Ports:
- pclk_i  in  1  pixel clock; the only clock.
- rstn_i  in  1  reset, synchronous, active-low.
- sof_i  in  1  start of frame; qualified by pix_valid_i and marks pixel (0,0).
- pix_valid_i  in  1  input pixel valid.
- pix_i  in  DATA_WIDTH  input pixel, raster order.
- fsync_o  out  1  frame active; goes to kernel fsync_i.
- rsync_o  out  1  window valid; goes to kernel rsync_i.
- pData1..pData9  out  DATA_WIDTH each  window taps, row-major; pData1 top-left, pData5 centre, pData9 bottom-right.
- frame_done_o  out  1  one-cycle pulse at normal frame completion.
- frame_abort_o  out  1  one-cycle pulse when sof_i restarts an unfinished frame.

Behaviour:
- Reset (rstn_i low at a pclk_i edge):
  - State goes to IDLE; col and row counters clear to 0.
  - fsync_o, rsync_o, frame_done_o, frame_abort_o, all window registers and all pData outputs go to 0.
  - Line-buffer RAM is not reset. Its contents are don't-care, because FILL overwrites them before use.
  - Reset mid-frame discards the frame silently; no done or abort pulse.
- Accept: a pixel is accepted when pix_valid_i=1 and either (state=IDLE and sof_i=1) or state is FILL/ACTIVE.
  - In IDLE, a valid pixel without sof_i is ignored.
  - With pix_valid_i=0, all state, counters and windows hold, and rsync_o=0 the next cycle.
- Line buffers: two arrays, lb1 (row r-1) and lb2 (row r-2), IMG_WIDTH deep.
  - On an accepted pixel at (row r, col c): tap_top=lb2[c] and tap_mid=lb1[c], both read-before-write (old data).
  - Writes in the same cycle: lb2[c]<=lb1[c] and lb1[c]<=pix_i.
- Window shift, on every accepted pixel:
  - Each window row shifts left: pData1<=pData2, pData2<=pData3, and likewise for the other rows.
  - Right column loads: pData3<=tap_top, pData6<=tap_mid, pData9<=pix_i.
- Counters:
  - col increments per accepted pixel and wraps at IMG_WIDTH-1 to 0.
  - On that wrap, row increments.
- Window valid: rsync_o is registered.
  - It is 1 in the cycle after an accepted pixel with row>=2 and col>=2; otherwise 0.
  - Latency from pixel accept to window out is 1 cycle. The window is centred at (row-1, col-1).
  - Valid windows per frame = (IMG_WIDTH-2)*(IMG_HEIGHT-2). Columns 0..1 of each row never raise rsync_o, so stale cross-line windows are suppressed.
- FSM:
  - IDLE -> FILL on an accepted sof pixel; counters start with that pixel at (0,0).
  - FILL -> ACTIVE on acceptance of pixel (1, IMG_WIDTH-1).
  - ACTIVE -> DONE on acceptance of pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
  - DONE -> IDLE unconditionally after one cycle. If pix_valid_i&sof_i is present in DONE, it is accepted as the new (0,0) and the FSM goes to FILL.
- fsync_o:
  - Registered; 1 in the cycle after the sof pixel is accepted, and stays 1 through the cycle that carries the last window.
  - Goes to 0 the following cycle, unless a new frame has started.
- frame_done_o: pulses in the cycle the FSM is in DONE, coincident with the final rsync_o=1.
- sof_i with pix_valid_i while in FILL/ACTIVE:
  - Pulse frame_abort_o the next cycle.
  - Treat that pixel as (0,0) of a new frame; state goes to FILL.
  - rsync_o for that pixel is 0; fsync_o stays 1; no frame_done_o.
- sof_i without pix_valid_i is ignored.
- Counter widths are $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT). There is no arithmetic overflow beyond wrap.

Test Plan:
- Continuous frame, IMG_WIDTH=8, IMG_HEIGHT=6, pixel value = row*16+col -> exactly 24 rsync_o pulses, the first one cycle after pixel (2,2) is accepted.
  - First window: pData1..9 = 0x00,0x01,0x02,0x10,0x11,0x12,0x20,0x21,0x22.
  - frame_done_o pulses once, coincident with the last window (pData9=0x57); fsync_o falls one cycle later.
- Same frame with pix_valid_i toggled 1/0 every cycle -> identical window sequence and count. rsync_o is never high in a cycle following pix_valid_i=0.
- Valid pixels before any sof_i, then a frame -> pre-sof pixels are ignored; the first window still equals the row 0..2 / col 0..2 pattern.
- sof_i re-asserted at pixel (3,4) of a frame -> frame_abort_o pulses once; no frame_done_o for the aborted frame; fsync_o stays 1.
  - The restarted frame produces 24 windows and one frame_done_o.
- rstn_i low for 1 cycle at pixel (4,5) -> next cycle all outputs are 0 and state is IDLE; no done or abort pulse. A following full frame yields 24 correct windows.
- Back-to-back frames with the sof pixel presented in the DONE cycle -> no pixel is lost and fsync_o stays 1 across the boundary. Each frame gives 24 windows and one frame_done_o.
